fdn_wsum: RTL

Parametrised single-clock successor of the FDN channel-weighting core: multiplies a time-multiplexed stream of complex channel samples by per-channel complex coefficients and accumulates them into one complex weighted sum per frame. Adds double-buffered coefficient banks with frame-aligned swap, frame-error detection, half-LSB rounding and optional saturation. Sits between the channel demultiplexer and the FDN output formatter; all arithmetic is in-fabric.

---
 rtl/fdn_pkg.sv | 15 +
 rtl/fdn_wsum_if.sv | 40 ++++
 rtl/fdn_cmult.sv | 52 +++++
 rtl/fdn_wsum.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fdn_pkg.sv
// Shared width helpers and the fixed pipeline depth of the FDN weighted-sum core.
package fdn_pkg;

  localparam int LATENCY = 5;

  // Complex product sum width: one full product plus the add/subtract growth bit.
  function automatic int pw(input int dw, input int cw);
    return dw + cw + 1;
  endfunction

  function automatic int aw(input int dw, input int cw, input int n_chan);
    return pw(dw, cw) + $clog2(n_chan);
  endfunction

endpackage

// File: rtl/fdn_wsum_if.sv
// Sample, coefficient-write and result bundle of fdn_wsum; no backpressure, so every
// signal flows one way apart from the result/status group.
interface fdn_wsum_if #(
  parameter int DW     = 25,
  parameter int CW     = 24,
  parameter int OW     = 32,
  parameter int N_CHAN = 32
);
  import fdn_pkg::*;

  localparam int CHW = $clog2(N_CHAN);

  logic                  in_vld;
  logic                  in_last;
  logic signed [DW-1:0]  in_re;
  logic signed [DW-1:0]  in_im;
  logic                  coef_we;
  logic [CHW-1:0]        coef_addr;
  logic signed [CW-1:0]  coef_re;
  logic signed [CW-1:0]  coef_im;
  logic                  coef_swap;
  logic                  out_vld;
  logic signed [OW-1:0]  out_re;
  logic signed [OW-1:0]  out_im;
  logic                  out_sat;
  logic                  err_frame;
  logic                  bank_sel;

  modport master (
    output in_vld, in_last, in_re, in_im,
    output coef_we, coef_addr, coef_re, coef_im, coef_swap,
    input  out_vld, out_re, out_im, out_sat, err_frame, bank_sel
  );

  modport slave (
    input  in_vld, in_last, in_re, in_im,
    input  coef_we, coef_addr, coef_re, coef_im, coef_swap,
    output out_vld, out_re, out_im, out_sat, err_frame, bank_sel
  );
endinterface

// File: rtl/fdn_cmult.sv
// 2-stage pipelined complex multiplier (products, then complex sum), full precision.
// Latency 2, valid and tag ride alongside the data; no backpressure.
module fdn_cmult #(
  parameter int DW = 25,
  parameter int CW = 24,
  parameter int TW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [TW-1:0]         in_tag,
  input  logic signed [DW-1:0]  ar,
  input  logic signed [DW-1:0]  ai,
  input  logic signed [CW-1:0]  br,
  input  logic signed [CW-1:0]  bi,
  output logic                  out_vld,
  output logic [TW-1:0]         out_tag,
  output logic signed [DW+CW:0] out_re,
  output logic signed [DW+CW:0] out_im
);
  import fdn_pkg::*;

  localparam int PRW = DW + CW;

  logic                  s1_vld;
  logic [TW-1:0]         s1_tag;
  logic signed [PRW-1:0] p_rr, p_ii, p_ri, p_ir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_tag  <= '0;
      out_vld <= 1'b0;
      out_tag <= '0;
    end else begin
      s1_vld  <= in_vld;
      s1_tag  <= in_tag;
      out_vld <= s1_vld;
      out_tag <= s1_tag;
    end
  end

  always_ff @(posedge clk) begin
    p_rr   <= PRW'(ar) * PRW'(br);
    p_ii   <= PRW'(ai) * PRW'(bi);
    p_ri   <= PRW'(ar) * PRW'(bi);
    p_ir   <= PRW'(ai) * PRW'(br);
    out_re <= (PRW+1)'(p_rr) - (PRW+1)'(p_ii);
    out_im <= (PRW+1)'(p_ri) + (PRW+1)'(p_ir);
  end

endmodule

// File: rtl/fdn_wsum.sv
// Per-frame complex weighted sum with double-buffered coefficients; latency 5, no backpressure
// (samples accepted whenever in_vld). FDN_WSUM_SAT_EN selects clamping instead of wrap on output.
module fdn_wsum
  import fdn_pkg::*;
#(
  parameter int DW     = 25,
  parameter int CW     = 24,
  parameter int OW     = 32,
  parameter int N_CHAN = 32,
  parameter int SHIFT  = 10
) (
  input  logic       clk,
  input  logic       rst,
  fdn_wsum_if.slave  io
);

  localparam int PW  = pw(DW, CW);
  localparam int AW  = aw(DW, CW, N_CHAN);
  localparam int CHW = $clog2(N_CHAN);
  localparam logic signed [AW:0] RND = (AW+1)'((2 ** SHIFT) / 2);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } samp_t;

  typedef struct packed {
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
  } coef_t;

  logic [CHW-1:0] ch;
  logic           pending, sel, err_q;
  logic           is_first, is_close, toggle, next_sel;

  assign is_first = (ch == '0);
  assign is_close = (ch == CHW'(N_CHAN - 1));

  // A ch=0 sample swaps banks before its own coefficient read.
  always_comb begin
    toggle   = io.in_vld && is_first && (pending || io.coef_swap);
    next_sel = sel ^ toggle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch      <= '0;
      pending <= 1'b0;
      sel     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (io.in_vld)
        ch <= (is_close || io.in_last) ? '0 : ch + 1'b1;
      pending <= toggle ? 1'b0 : (pending | io.coef_swap);
      sel     <= next_sel;
      err_q   <= io.in_vld && (is_close != io.in_last);
    end
  end

  coef_t bank [2][N_CHAN];

  always_ff @(posedge clk) begin
    if (io.coef_we)
      bank[~next_sel][io.coef_addr] <= coef_t'{re: io.coef_re, im: io.coef_im};
  end

  // S0: sample and its coefficient registered together.
  logic  s0_vld, s0_first, s0_close;
  samp_t s0_smp;
  coef_t s0_coef;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_vld   <= 1'b0;
      s0_first <= 1'b0;
      s0_close <= 1'b0;
    end else begin
      s0_vld   <= io.in_vld;
      s0_first <= is_first;
      s0_close <= is_close;
    end
  end

  always_ff @(posedge clk) begin
    if (io.in_vld) begin
      s0_smp  <= samp_t'{re: io.in_re, im: io.in_im};
      s0_coef <= bank[next_sel][ch];
    end
  end

  logic                 s2_vld;
  logic [1:0]           s2_tag;
  logic signed [PW-1:0] s2_re, s2_im;

  fdn_cmult #(.DW(DW), .CW(CW), .TW(2)) u_cmult (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (s0_vld),
    .in_tag  ({s0_first, s0_close}),
    .ar      (s0_smp.re),
    .ai      (s0_smp.im),
    .br      (s0_coef.re),
    .bi      (s0_coef.im),
    .out_vld (s2_vld),
    .out_tag (s2_tag),
    .out_re  (s2_re),
    .out_im  (s2_im)
  );

  // S3: an aborted frame never closes, so its partial sum is simply overwritten at the next ch=0.
  logic signed [AW-1:0] acc_re, acc_im;
  logic                 s3_close;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s3_close <= 1'b0;
    else      s3_close <= s2_vld && s2_tag[0];
  end

  always_ff @(posedge clk) begin
    if (s2_vld) begin
      acc_re <= s2_tag[1] ? AW'(s2_re) : acc_re + AW'(s2_re);
      acc_im <= s2_tag[1] ? AW'(s2_im) : acc_im + AW'(s2_im);
    end
  end

  // Returns {saturated, value}; rounding is half-up before the arithmetic shift.
  function automatic logic [OW:0] reduce(input logic signed [AW-1:0] a);
    logic signed [AW:0] r;
    r = ((AW+1)'(a) + RND) >>> SHIFT;
`ifdef FDN_WSUM_SAT_EN
    if (r[AW:OW-1] != {(AW-OW+2){r[AW]}})
      return {1'b1, r[AW], {(OW-1){~r[AW]}}};
`endif
    return {1'b0, r[OW-1:0]};
  endfunction

  logic [OW:0] red_re, red_im;

  always_comb begin
    red_re = reduce(acc_re);
    red_im = reduce(acc_im);
  end

  logic                 out_vld_q, out_sat_q;
  logic signed [OW-1:0] out_re_q, out_im_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_q <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
      out_sat_q <= 1'b0;
    end else begin
      out_vld_q <= s3_close;
      if (s3_close) begin
        out_re_q  <= red_re[OW-1:0];
        out_im_q  <= red_im[OW-1:0];
        out_sat_q <= red_re[OW] | red_im[OW];
      end
    end
  end

  assign io.out_vld   = out_vld_q;
  assign io.out_re    = out_re_q;
  assign io.out_im    = out_im_q;
  assign io.out_sat   = out_sat_q;
  assign io.err_frame = err_q;
  assign io.bank_sel  = sel;

endmodule
